// File: rtl/clock_mode_ctrl_multi.sv
// Mode controller for the digital clock: mode FSM, display mux,
// multi-slot alarm supervisor with a timed ring window.
// Optional feature macro: CLOCK_SNOOZE_EN (adds snooze_btn and snooze logic).
// Ports:
//   clk, rst (async, active-high)
//   mode_btn, alarm_ack, sw_ack, set_ack -> mode_en, load_time
//   sec_tick, normal_hours/minutes, alarm_hours/minutes,
//   alarm_arm/disarm, stop_btn[, snooze_btn] -> alarm_armed,
//   alarm_sound, ring_idx
//   sw_minutes/seconds, set_hours/minutes -> hours_disp, minutes_disp
module clock_mode_ctrl_multi #(
  parameter int NUM_ALARMS  = 2,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_btn,
  input  logic                    alarm_ack,
  input  logic                    sw_ack,
  input  logic                    set_ack,
  input  logic                    sec_tick,
  input  logic [4:0]              normal_hours,
  input  logic [5:0]              normal_minutes,
  input  logic [5*NUM_ALARMS-1:0] alarm_hours,
  input  logic [6*NUM_ALARMS-1:0] alarm_minutes,
  input  logic [NUM_ALARMS-1:0]   alarm_arm,
  input  logic [NUM_ALARMS-1:0]   alarm_disarm,
  input  logic                    stop_btn,
`ifdef CLOCK_SNOOZE_EN
  input  logic                    snooze_btn,
`endif
  input  logic [5:0]              sw_minutes,
  input  logic [5:0]              sw_seconds,
  input  logic [4:0]              set_hours,
  input  logic [5:0]              set_minutes,
  output logic [3:0]              mode_en,
  output logic                    load_time,
  output logic [NUM_ALARMS-1:0]   alarm_armed,
  output logic                    alarm_sound,
  output logic [2:0]              ring_idx,
  output logic [5:0]              hours_disp,
  output logic [5:0]              minutes_disp
);

  // One-hot encoding so mode_en is the state register itself
  typedef enum logic [3:0] {
    S_NORMAL = 4'b0001,
    S_ALARM  = 4'b0010,
    S_SW     = 4'b0100,
    S_SET    = 4'b1000
  } state_t;

  localparam logic [7:0] RING_CNT = 8'(RING_SECS);

  state_t state, state_d;
  logic   load_d;
  logic   mode_btn_q;
  logic   btn_edge;
  logic [5:0] prev_min;
  logic   rollover;
  logic [7:0] ring_cnt;
  logic [NUM_ALARMS-1:0] fire;
  logic [2:0] fire_idx;

  assign btn_edge = mode_btn & ~mode_btn_q;
  assign rollover = normal_minutes != prev_min;
  assign mode_en  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_NORMAL;
      load_time  <= 1'b0;
      mode_btn_q <= 1'b0;
      prev_min   <= '0;
    end else begin
      state      <= state_d;
      load_time  <= load_d;
      mode_btn_q <= mode_btn;
      prev_min   <= normal_minutes;
    end
  end

  always_comb begin
    state_d = state;
    load_d  = 1'b0;
    case (state)
      S_NORMAL:
        if (btn_edge) state_d = S_ALARM;
      S_ALARM:
        if (btn_edge && alarm_ack) state_d = S_SW;
      S_SW:
        if (btn_edge && sw_ack) state_d = S_SET;
      S_SET:
        if (btn_edge && set_ack) begin
          state_d = S_NORMAL;
          load_d  = 1'b1;
        end
      default:
        state_d = S_NORMAL;
    endcase
  end

  always_comb begin
    hours_disp   = {1'b0, normal_hours};
    minutes_disp = normal_minutes;
    case (state)
      S_ALARM: begin
        hours_disp   = {1'b0, alarm_hours[4:0]};
        minutes_disp = alarm_minutes[5:0];
      end
      S_SW: begin
        hours_disp   = sw_minutes;
        minutes_disp = sw_seconds;
      end
      S_SET: begin
        hours_disp   = {1'b0, set_hours};
        minutes_disp = set_minutes;
      end
      default: ;
    endcase
  end

  // Matching only on a rollover cycle limits each slot to one fire per minute
  always_comb begin
    fire     = '0;
    fire_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      fire[i] = rollover && alarm_armed[i] &&
                (alarm_hours[5*i +: 5] == normal_hours) &&
                (alarm_minutes[6*i +: 6] == normal_minutes);
    end
    for (int i = NUM_ALARMS-1; i >= 0; i--) begin
      if (fire[i]) fire_idx = 3'(i);
    end
  end

  // Disarm wins over arm; firing slots are one-shot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_armed <= '0;
    end else begin
      alarm_armed <= (alarm_armed | alarm_arm) & ~alarm_disarm & ~fire;
    end
  end

`ifdef CLOCK_SNOOZE_EN
  localparam logic [3:0] SNZ_CNT = 4'(SNOOZE_MINS);
  logic       snz_pend;
  logic [3:0] snz_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_sound <= 1'b0;
      ring_idx    <= '0;
      ring_cnt    <= '0;
`ifdef CLOCK_SNOOZE_EN
      snz_pend    <= 1'b0;
      snz_cnt     <= '0;
`endif
    end else if (|fire) begin
      alarm_sound <= 1'b1;
      ring_cnt    <= RING_CNT;
      ring_idx    <= fire_idx;
`ifdef CLOCK_SNOOZE_EN
      snz_pend    <= 1'b0;
      snz_cnt     <= '0;
`endif
    end else if (stop_btn) begin
      alarm_sound <= 1'b0;
      ring_cnt    <= '0;
`ifdef CLOCK_SNOOZE_EN
      snz_pend    <= 1'b0;
      snz_cnt     <= '0;
    end else if (snooze_btn) begin
      // Snooze while idle just cancels a pending snooze
      alarm_sound <= 1'b0;
      ring_cnt    <= '0;
      snz_pend    <= alarm_sound;
      snz_cnt     <= alarm_sound ? SNZ_CNT : 4'd0;
    end else if (snz_pend && rollover) begin
      if (snz_cnt <= 4'd1) begin
        alarm_sound <= 1'b1;
        ring_cnt    <= RING_CNT;
        snz_pend    <= 1'b0;
        snz_cnt     <= '0;
      end else begin
        snz_cnt <= snz_cnt - 4'd1;
      end
`endif
    end else if (alarm_sound) begin
      // Sound drops one cycle after the counter hits zero
      if (ring_cnt == 8'd0) begin
        alarm_sound <= 1'b0;
      end else if (sec_tick) begin
        ring_cnt <= ring_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl_multi.sv
// Self-checking bench for clock_mode_ctrl_multi.
// Table-driven mode FSM vectors plus directed alarm sequences.
module tb_clock_mode_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_btn, alarm_ack, sw_ack, set_ack, sec_tick;
  logic [4:0]  normal_hours;
  logic [5:0]  normal_minutes;
  logic [9:0]  alarm_hours;
  logic [11:0] alarm_minutes;
  logic [1:0]  alarm_arm, alarm_disarm;
  logic        stop_btn;
`ifdef CLOCK_SNOOZE_EN
  logic        snooze_btn;
`endif
  logic [5:0]  sw_minutes, sw_seconds;
  logic [4:0]  set_hours;
  logic [5:0]  set_minutes;
  logic [3:0]  mode_en;
  logic        load_time;
  logic [1:0]  alarm_armed;
  logic        alarm_sound;
  logic [2:0]  ring_idx;
  logic [5:0]  hours_disp, minutes_disp;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl_multi #(
    .NUM_ALARMS(2), .RING_SECS(3), .SNOOZE_MINS(2)
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn),
    .alarm_ack(alarm_ack), .sw_ack(sw_ack), .set_ack(set_ack),
    .sec_tick(sec_tick), .normal_hours(normal_hours),
    .normal_minutes(normal_minutes), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .alarm_arm(alarm_arm),
    .alarm_disarm(alarm_disarm), .stop_btn(stop_btn),
`ifdef CLOCK_SNOOZE_EN
    .snooze_btn(snooze_btn),
`endif
    .sw_minutes(sw_minutes), .sw_seconds(sw_seconds),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .mode_en(mode_en), .load_time(load_time),
    .alarm_armed(alarm_armed), .alarm_sound(alarm_sound),
    .ring_idx(ring_idx), .hours_disp(hours_disp),
    .minutes_disp(minutes_disp)
  );

  typedef struct {
    logic       btn;
    logic       aa;
    logic       sa;
    logic       ta;
    logic [3:0] mode;
    logic       load;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0};

    rst = 1'b1;
    mode_btn = 0; alarm_ack = 0; sw_ack = 0; set_ack = 0;
    sec_tick = 0; stop_btn = 0;
`ifdef CLOCK_SNOOZE_EN
    snooze_btn = 0;
`endif
    normal_hours = 0; normal_minutes = 0;
    alarm_hours = '0; alarm_minutes = '0;
    alarm_arm = '0; alarm_disarm = '0;
    sw_minutes = 0; sw_seconds = 0;
    set_hours = 0; set_minutes = 0;

    #3;
    chk("reset_mode", 8'(mode_en), 8'h01);
    chk("reset_load", 8'(load_time), 8'h00);
    chk("reset_armed", 8'(alarm_armed), 8'h00);
    chk("reset_sound", 8'(alarm_sound), 8'h00);
    chk("reset_idx", 8'(ring_idx), 8'h00);
    #4 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      mode_btn  = vt[i].btn;
      alarm_ack = vt[i].aa;
      sw_ack    = vt[i].sa;
      set_ack   = vt[i].ta;
      tick();
      chk($sformatf("vec%0d_mode", i), 8'(mode_en), 8'(vt[i].mode));
      chk($sformatf("vec%0d_load", i), 8'(load_time), 8'(vt[i].load));
    end
    alarm_ack = 0; sw_ack = 0; set_ack = 0;

    // Slot1 fires in STOPWATCH mode
    normal_hours = 7; normal_minutes = 29;
    alarm_hours = {5'd7, 5'd9};
    alarm_minutes = {6'd30, 6'd15};
    sw_minutes = 12; sw_seconds = 34;
    tick();
    alarm_arm = 2'b10; tick(); alarm_arm = 2'b00;
    chk("arm_slot1", 8'(alarm_armed), 8'h02);
    normal_minutes = 30; tick();
    chk("sw_fire_sound", 8'(alarm_sound), 8'h01);
    chk("sw_fire_idx", 8'(ring_idx), 8'h01);
    chk("sw_fire_disarm", 8'(alarm_armed), 8'h00);
    chk("sw_fire_mode", 8'(mode_en), 8'h04);
    chk("sw_disp_h", 8'(hours_disp), 8'd12);
    chk("sw_disp_m", 8'(minutes_disp), 8'd34);
    stop_btn = 1; tick(); stop_btn = 0;
    chk("stop_silence", 8'(alarm_sound), 8'h00);

    // Arm and disarm together resolve to disarmed
    alarm_arm = 2'b01; alarm_disarm = 2'b01; tick();
    alarm_arm = 0; alarm_disarm = 0;
    chk("arm_disarm_same", 8'(alarm_armed), 8'h00);
    alarm_arm = 2'b01; tick(); alarm_arm = 0;
    chk("arm_slot0", 8'(alarm_armed), 8'h01);
    alarm_disarm = 2'b01; tick(); alarm_disarm = 0;
    chk("disarm_slot0", 8'(alarm_armed), 8'h00);

    // Both slots at 12:00; lowest index wins; ring window of 3 ticks
    alarm_hours = {5'd12, 5'd12};
    alarm_minutes = {6'd0, 6'd0};
    normal_hours = 11; normal_minutes = 59; tick();
    alarm_arm = 2'b11; tick(); alarm_arm = 0;
    chk("arm_both", 8'(alarm_armed), 8'h03);
    normal_hours = 12; normal_minutes = 0; tick();
    chk("dual_fire_sound", 8'(alarm_sound), 8'h01);
    chk("dual_fire_idx", 8'(ring_idx), 8'h00);
    chk("dual_fire_disarm", 8'(alarm_armed), 8'h00);
    for (int k = 0; k < 2; k++) begin
      sec_tick = 1; tick(); sec_tick = 0; tick();
    end
    chk("ring_after_2", 8'(alarm_sound), 8'h01);
    sec_tick = 1; tick(); sec_tick = 0;
    chk("ring_at_zero", 8'(alarm_sound), 8'h01);
    tick();
    chk("ring_expired", 8'(alarm_sound), 8'h00);

    // Walk modes and check the display mux
    set_hours = 21; set_minutes = 45;
    alarm_hours = {5'd3, 5'd12};
    alarm_minutes = {6'd7, 6'd1};
    alarm_ack = 1; sw_ack = 1; set_ack = 1;
    mode_btn = 1; tick();
    chk("set_mode", 8'(mode_en), 8'h08);
    chk("set_disp_h", 8'(hours_disp), 8'd21);
    chk("set_disp_m", 8'(minutes_disp), 8'd45);
    mode_btn = 0; tick();
    mode_btn = 1; tick();
    chk("norm_mode", 8'(mode_en), 8'h01);
    chk("norm_load", 8'(load_time), 8'h01);
    chk("norm_disp_h", 8'(hours_disp), 8'd12);
    chk("norm_disp_m", 8'(minutes_disp), 8'd0);
    mode_btn = 0; tick();
    chk("load_pulse_end", 8'(load_time), 8'h00);
    mode_btn = 1; tick();
    chk("alarm_mode", 8'(mode_en), 8'h02);
    chk("alarm_disp_h", 8'(hours_disp), 8'd12);
    chk("alarm_disp_m", 8'(minutes_disp), 8'd1);
    mode_btn = 0; tick();
    alarm_ack = 0; sw_ack = 0; set_ack = 0;

    // Fire beats a coincident stop
    alarm_arm = 2'b01; tick(); alarm_arm = 0;
    normal_minutes = 1; stop_btn = 1; tick(); stop_btn = 0;
    chk("fire_beats_stop", 8'(alarm_sound), 8'h01);
    chk("fire_stop_idx", 8'(ring_idx), 8'h00);
    alarm_arm = 2'b10; tick(); alarm_arm = 0;
    chk("armed_pre_rst", 8'(alarm_armed), 8'h02);

    // Async reset mid-ring, between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", 8'(mode_en), 8'h01);
    chk("arst_sound", 8'(alarm_sound), 8'h00);
    chk("arst_armed", 8'(alarm_armed), 8'h00);
    #2 rst = 1'b0;

`ifdef CLOCK_SNOOZE_EN
    alarm_hours = {5'd6, 5'd0};
    alarm_minutes = {6'd0, 6'd0};
    normal_hours = 5; normal_minutes = 59; tick();
    alarm_arm = 2'b10; tick(); alarm_arm = 0;
    normal_hours = 6; normal_minutes = 0; tick();
    chk("snz_fire", 8'(alarm_sound), 8'h01);
    chk("snz_fire_idx", 8'(ring_idx), 8'h01);
    snooze_btn = 1; tick(); snooze_btn = 0;
    chk("snz_silent", 8'(alarm_sound), 8'h00);
    normal_minutes = 1; tick();
    chk("snz_0601", 8'(alarm_sound), 8'h00);
    normal_minutes = 2; tick();
    chk("snz_0602", 8'(alarm_sound), 8'h01);
    chk("snz_idx_kept", 8'(ring_idx), 8'h01);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
